// File: rtl/mult_pkg.sv
// Shared widths and the operand-stage record for the multiplier scheduler.
package mult_pkg;
  localparam int MULT_W  = 16;
  localparam int PROD_W  = 32;
  localparam int ID_MAXW = 4;

  typedef struct packed {
    logic [MULT_W-1:0]  x;
    logic [MULT_W-1:0]  y;
    logic [ID_MAXW-1:0] id;
  } mult_op_t;
endpackage

// File: rtl/LOBOq2_10bit_1C_v2.sv
// Approximate 16x16 multiplier: each operand keeps the 10 bits below and including
// its leading one, lower bits are dropped, and the truncated operands multiply exactly.
module LOBOq2_10bit_1C_v2 (
  input  logic [15:0] X_vec,
  input  logic [15:0] Y_vec,
  output logic [31:0] P_vec
);
  function automatic logic [3:0] trunc_sh(input logic [15:0] v);
    logic [3:0] lead;
    lead = '0;
    for (int i = 0; i < 16; i++)
      if (v[i]) lead = 4'(i);
    return (lead > 4'd9) ? lead - 4'd9 : 4'd0;
  endfunction

  logic [3:0]  sx, sy;
  logic [15:0] xt, yt;

  assign sx    = trunc_sh(X_vec);
  assign sy    = trunc_sh(Y_vec);
  assign xt    = (X_vec >> sx) << sx;
  assign yt    = (Y_vec >> sy) << sy;
  assign P_vec = {16'b0, xt} * {16'b0, yt};
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans from ptr upward, grant gated by adv, ptr moves past each winner.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     win,
  output logic               any
);
  logic [IDW-1:0] ptr;

  always_comb begin
    int idx;
    idx = 0;
    win = '0;
    any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        any = 1'b1;
        win = IDW'(idx);
      end
    end
    gnt = '0;
    if (any && adv) gnt[win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      ptr <= '0;
    else if (any && adv)
      ptr <= IDW'((int'(win) + 1) % NUM_REQ);
  end
endmodule

// File: rtl/mult_rr_scheduler.sv
// Shares one approximate multiplier among NUM_REQ clients: RR issue, operand stage,
// product stage, results tagged with the issuing requester's index.
module mult_rr_scheduler
  import mult_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*MULT_W-1:0] req_x,
  input  logic [NUM_REQ*MULT_W-1:0] req_y,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [PROD_W-1:0]         res_p,
  output logic [IDW-1:0]            res_id,
  output logic                      idle
);
  mult_op_t          s1_op;
  logic              s1_valid, s2_valid;
  logic              adv, any;
  logic [IDW-1:0]    win;
  logic [PROD_W-1:0] p_vec;

  // Reset gates adv so no grant is visible while rst_n is low.
  assign adv = (!s2_valid || res_ready) && rst_n;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .adv   (adv),
    .gnt   (req_ready),
    .win   (win),
    .any   (any)
  );

  LOBOq2_10bit_1C_v2 u_mult (
    .X_vec (s1_op.x),
    .Y_vec (s1_op.y),
    .P_vec (p_vec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_op    <= '0;
      res_p    <= '0;
      res_id   <= '0;
    end else if (adv) begin
      s1_valid <= any;
      if (any) begin
        s1_op.x  <= req_x[MULT_W*win +: MULT_W];
        s1_op.y  <= req_y[MULT_W*win +: MULT_W];
        s1_op.id <= ID_MAXW'(win);
      end
      s2_valid <= s1_valid;
      res_p    <= p_vec;
      res_id   <= s1_op.id[IDW-1:0];
    end
  end

  logic unused_id;
  assign unused_id = &{1'b0, s1_op.id};

  assign res_valid = s2_valid;
  assign idle      = !s1_valid && !s2_valid;
endmodule
